// File: rtl/fwrisc_pkg.sv
// Shared definitions for the fwrisc fetch stage: FSM encoding, the RVC
// length-detect constant and the default reset vector.
package fwrisc_pkg;

  // Fetch FSM states.
  // REQ    : bus request outstanding (or a buffered word is being decoded)
  // REQ_HI : fetching the upper word of a halfword-misaligned 32-bit instr
  // HOLD   : instruction presented to decode, waiting for decode_complete
  typedef enum logic [1:0] {
    FETCH_REQ    = 2'd0,
    FETCH_REQ_HI = 2'd1,
    FETCH_HOLD   = 2'd2
  } fetch_state_e;

  // Low two bits of a 32-bit (uncompressed) RISC-V instruction.
  localparam logic [1:0] RVC_UNCOMPRESSED = 2'b11;

  // Default program counter after reset.
  localparam logic [31:0] FWRISC_RESET_VECTOR = 32'h8000_0000;

  // A halfword starts a 16-bit instruction unless its low bits are 2'b11.
  function automatic logic is_compressed(input logic [1:0] lsb);
    return lsb != RVC_UNCOMPRESSED;
  endfunction

endpackage

// File: rtl/fwrisc_fetch_buf.sv
// One-word instruction buffer: remembers the last word taken from the bus
// and its word address so a following halfword in the same word is served
// without a second bus transaction.
module fwrisc_fetch_buf (
  input  logic        clock,
  input  logic        reset,
  // lookup: combinational hit against the stored tag
  input  logic [31:0] lookup_addr_i,
  output logic        lookup_hit_o,
  output logic [31:0] lookup_word_o,
  // fill: replaces the stored word on every bus accept
  input  logic        fill_i,
  input  logic [29:0] fill_tag_i,
  input  logic [31:0] fill_word_i
);

  logic        valid_q;
  logic [29:0] tag_q;
  logic [31:0] word_q;
  logic        unused_bits;

  // Capture each word accepted from the bus; invalid until the first fill.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      word_q  <= fill_word_i;
    end
  end

  assign lookup_hit_o  = valid_q && (tag_q == lookup_addr_i[31:2]);
  assign lookup_word_o = word_q;

  // Halfword offset does not take part in the word match.
  assign unused_bits = ^lookup_addr_i[1:0];

endmodule

// File: rtl/fwrisc_fetch.sv
// Instruction fetch stage of the fwrisc core. Owns the PC, issues
// word-aligned bus requests and presents one instruction at a time to
// decode. With ENABLE_COMPRESSED it aligns 16-bit and halfword-misaligned
// 32-bit instructions and reuses the last fetched word when possible.
//
// Handshakes:
//  - Instruction bus: a transfer happens on a rising edge where ivalid and
//    iready are both 1; idata is valid in that same cycle. While ivalid=1 and
//    iready=0, ivalid and iaddr do not change. Reset drops ivalid at once and
//    abandons the request.
//  - Decode: instr/instr_c/pc are valid while fetch_valid=1 and stay stable
//    until an edge with decode_complete=1 consumes them. decode_complete and
//    pc_redirect are ignored while fetch_valid=0.
module fwrisc_fetch
  import fwrisc_pkg::*;
#(
  parameter int unsigned ENABLE_COMPRESSED = 0,
  parameter logic [31:0] RESET_VECTOR      = FWRISC_RESET_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] iaddr,
  output logic        ivalid,
  input  logic        iready,
  input  logic [31:0] idata,
  output logic        fetch_valid,
  input  logic        decode_complete,
  output logic [31:0] instr,
  output logic        instr_c,
  output logic [31:0] pc,
  input  logic        pc_redirect,
  input  logic [31:0] pc_target,
  output logic [1:0]  state_dbg
);

  localparam logic EN_C = (ENABLE_COMPRESSED != 0);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  iaddr_q;
  logic [31:0]  instr_q;
  logic         instr_c_q;
  logic         ivalid_q;
  logic         fetch_valid_q;
  logic         buf_use_q;     // decode the buffered word instead of the bus
  logic [15:0]  half_q;        // low half of a word-spanning 32-bit instr

  logic         bus_accept;
  logic         buf_hit;
  logic [31:0]  buf_word;
  logic [31:0]  cap_word;
  logic         cap_hi;
  logic [15:0]  cap_half;
  logic         cap_is_c;
  logic         cap_span;
  logic [31:0]  target_masked;
  logic [31:0]  pc_incr;
  logic [31:0]  next_pc;
  logic         unused_bits;

  assign bus_accept = ivalid_q & iready;

  // Word being decoded: the buffer on a hit, otherwise the bus data.
  assign cap_word = buf_use_q ? buf_word : idata;
  // Without RVC the PC is always word aligned, so only the low half matters.
  assign cap_hi   = EN_C & pc_q[1];
  assign cap_half = cap_hi ? cap_word[31:16] : cap_word[15:0];
  assign cap_is_c = EN_C & is_compressed(cap_half[1:0]);
  // A 32-bit instruction starting in the upper half needs the next word.
  assign cap_span = cap_hi & ~cap_is_c;

  // Redirect targets are halfword aligned with RVC, word aligned without.
  assign target_masked = EN_C ? {pc_target[31:1], 1'b0} : {pc_target[31:2], 2'b00};
  assign pc_incr       = instr_c_q ? 32'd2 : 32'd4;
  assign next_pc       = pc_redirect ? target_masked : pc_q + pc_incr;

  generate
    if (EN_C) begin : g_buf
      fwrisc_fetch_buf u_buf (
        .clock         (clock),
        .reset         (reset),
        .lookup_addr_i (next_pc),
        .lookup_hit_o  (buf_hit),
        .lookup_word_o (buf_word),
        .fill_i        (bus_accept),
        .fill_tag_i    (iaddr_q[31:2]),
        .fill_word_i   (idata)
      );
    end else begin : g_no_buf
      assign buf_hit  = 1'b0;
      assign buf_word = 32'h0;
    end
  endgenerate

  // Fetch FSM: request, optional upper-word request, hold for decode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH_REQ;
      pc_q          <= RESET_VECTOR;
      iaddr_q       <= {RESET_VECTOR[31:2], 2'b00};
      instr_q       <= 32'h0;
      instr_c_q     <= 1'b0;
      ivalid_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      buf_use_q     <= 1'b0;
      half_q        <= 16'h0;
    end else begin
      case (state_q)
        FETCH_REQ: begin
          if (buf_use_q || bus_accept) begin
            buf_use_q <= 1'b0;
            if (cap_span) begin
              half_q   <= cap_half;
              iaddr_q  <= {pc_q[31:2] + 30'd1, 2'b00};
              ivalid_q <= 1'b1;
              state_q  <= FETCH_REQ_HI;
            end else begin
              instr_q       <= cap_is_c ? {16'h0, cap_half} : cap_word;
              instr_c_q     <= cap_is_c;
              ivalid_q      <= 1'b0;
              fetch_valid_q <= 1'b1;
              state_q       <= FETCH_HOLD;
            end
          end else if (!ivalid_q) begin
            // First cycle after reset: raise the request.
            ivalid_q <= 1'b1;
          end
        end
        FETCH_REQ_HI: begin
          if (bus_accept) begin
            instr_q       <= {idata[15:0], half_q};
            instr_c_q     <= 1'b0;
            ivalid_q      <= 1'b0;
            fetch_valid_q <= 1'b1;
            state_q       <= FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (decode_complete) begin
            pc_q          <= next_pc;
            iaddr_q       <= {next_pc[31:2], 2'b00};
            fetch_valid_q <= 1'b0;
            state_q       <= FETCH_REQ;
            if (buf_hit) begin
              buf_use_q <= 1'b1;
              ivalid_q  <= 1'b0;
            end else begin
              ivalid_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= FETCH_REQ;
        end
      endcase
    end
  end

  assign iaddr       = iaddr_q;
  assign ivalid      = ivalid_q;
  assign fetch_valid = fetch_valid_q;
  assign instr       = instr_q;
  assign instr_c     = instr_c_q;
  assign pc          = pc_q;
  assign state_dbg   = state_q;

  // Redirect bit 0 is always discarded.
  assign unused_bits = pc_target[0];

endmodule

// File: tb/tb_fwrisc_fetch.sv
// Bench for fwrisc_fetch: one instance without RVC and one with RVC, fed
// from a shared 64-word memory image. Directed steps first, then random
// bus/decode traffic checked against a halfword-level fetch model.
module tb_fwrisc_fetch;

  logic        clock = 1'b0;
  logic        reset           [2];
  logic [31:0] iaddr           [2];
  logic        ivalid          [2];
  logic        iready          [2];
  logic [31:0] idata           [2];
  logic        fetch_valid     [2];
  logic        decode_complete [2];
  logic [31:0] instr           [2];
  logic        instr_c         [2];
  logic [31:0] pc              [2];
  logic        pc_redirect     [2];
  logic [31:0] pc_target       [2];
  logic [1:0]  state_dbg       [2];

  logic [31:0] mem [64];
  int checks   = 0;
  int failures = 0;
  int acc [2]  = '{0, 0};

  // clock
  always #5 clock = ~clock;

  fwrisc_fetch #(.ENABLE_COMPRESSED(0)) u_dut0 (
    .clock(clock), .reset(reset[0]), .iaddr(iaddr[0]), .ivalid(ivalid[0]),
    .iready(iready[0]), .idata(idata[0]), .fetch_valid(fetch_valid[0]),
    .decode_complete(decode_complete[0]), .instr(instr[0]), .instr_c(instr_c[0]),
    .pc(pc[0]), .pc_redirect(pc_redirect[0]), .pc_target(pc_target[0]),
    .state_dbg(state_dbg[0])
  );

  fwrisc_fetch #(.ENABLE_COMPRESSED(1)) u_dut1 (
    .clock(clock), .reset(reset[1]), .iaddr(iaddr[1]), .ivalid(ivalid[1]),
    .iready(iready[1]), .idata(idata[1]), .fetch_valid(fetch_valid[1]),
    .decode_complete(decode_complete[1]), .instr(instr[1]), .instr_c(instr_c[1]),
    .pc(pc[1]), .pc_redirect(pc_redirect[1]), .pc_target(pc_target[1]),
    .state_dbg(state_dbg[1])
  );

  // bus transaction counter
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++)
      if (reset[d] === 1'b1 && ivalid[d] === 1'b1 && iready[d] === 1'b1)
        acc[d] <= acc[d] + 1;
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic refresh_bus();
    for (int d = 0; d < 2; d++) idata[d] = mem[iaddr[d][7:2]];
  endtask

  // advance one clock; inputs are changed and outputs sampled at negedge
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    refresh_bus();
  endtask

  // reference model helpers
  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] align_target(input int d, input logic [31:0] t);
    return (d == 0) ? (t & 32'hFFFF_FFFC) : (t & 32'hFFFF_FFFE);
  endfunction

  logic [31:0] m_pc    [2];
  logic [31:0] m_len   [2];
  int          idle    [2];
  logic        prev_iv [2];
  logic        prev_rdy[2];
  logic        prev_fv [2];
  logic [31:0] prev_ia [2];
  logic [31:0] e_instr;
  logic        e_c;
  logic [15:0] h;
  int          a0;
  bit          abort;

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b0; iready[d] = 1'b0; decode_complete[d] = 1'b0;
      pc_redirect[d] = 1'b0; pc_target[d] = 32'h0; idata[d] = 32'h0;
    end
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h0000_4505;
    mem[63] = 32'h1234_5677;

    // ---------------- non-RVC instance ----------------
    step(); step();
    check32("rst_pc", pc[0], 32'h8000_0000);
    check32("rst_iaddr", iaddr[0], 32'h8000_0000);
    check1("rst_ivalid", ivalid[0], 1'b0);
    check1("rst_fetch_valid", fetch_valid[0], 1'b0);
    check32("rst_instr", instr[0], 32'h0);
    check1("rst_instr_c", instr_c[0], 1'b0);

    reset[0] = 1'b1;
    step();
    check1("req_ivalid", ivalid[0], 1'b1);
    check32("req_iaddr", iaddr[0], 32'h8000_0000);
    for (int k = 0; k < 3; k++) begin
      step();
      check1("stall_ivalid", ivalid[0], 1'b1);
      check32("stall_iaddr", iaddr[0], 32'h8000_0000);
      check1("stall_fetch_valid", fetch_valid[0], 1'b0);
    end
    iready[0] = 1'b1;
    step();
    iready[0] = 1'b0;
    check1("first_fetch_valid", fetch_valid[0], 1'b1);
    check32("first_pc", pc[0], 32'h8000_0000);
    check32("first_instr", instr[0], 32'h0050_0093);
    check1("first_instr_c", instr_c[0], 1'b0);
    check1("first_ivalid_low", ivalid[0], 1'b0);

    // redirect without decode_complete is ignored
    pc_redirect[0] = 1'b1; pc_target[0] = 32'h8000_0200;
    step();
    pc_redirect[0] = 1'b0;
    check1("lone_redirect_fv", fetch_valid[0], 1'b1);
    check32("lone_redirect_pc", pc[0], 32'h8000_0000);
    check1("lone_redirect_ivalid", ivalid[0], 1'b0);

    decode_complete[0] = 1'b1;
    step();
    decode_complete[0] = 1'b0;
    check1("seq_fetch_valid", fetch_valid[0], 1'b0);
    check1("seq_ivalid", ivalid[0], 1'b1);
    check32("seq_iaddr", iaddr[0], 32'h8000_0004);
    check32("seq_pc", pc[0], 32'h8000_0004);

    // compressed-looking word is a plain 32-bit word without RVC
    iready[0] = 1'b1;
    step();
    iready[0] = 1'b0;
    check32("norvc_instr", instr[0], 32'h0000_4505);
    check1("norvc_instr_c", instr_c[0], 1'b0);

    // redirect with low bits set: both low bits cleared
    decode_complete[0] = 1'b1; pc_redirect[0] = 1'b1; pc_target[0] = 32'h8000_0103;
    step();
    decode_complete[0] = 1'b0; pc_redirect[0] = 1'b0;
    check32("redir_iaddr", iaddr[0], 32'h8000_0100);
    check32("redir_pc", pc[0], 32'h8000_0100);
    check1("redir_ivalid", ivalid[0], 1'b1);
    iready[0] = 1'b1;
    step();
    iready[0] = 1'b0;
    check32("redir_instr", instr[0], 32'h0050_0093);

    // PC wrap at the top of the address space
    decode_complete[0] = 1'b1; pc_redirect[0] = 1'b1; pc_target[0] = 32'hFFFF_FFFC;
    step();
    decode_complete[0] = 1'b0; pc_redirect[0] = 1'b0;
    check32("top_iaddr", iaddr[0], 32'hFFFF_FFFC);
    iready[0] = 1'b1;
    step();
    iready[0] = 1'b0;
    check32("top_instr", instr[0], 32'h1234_5677);
    decode_complete[0] = 1'b1;
    step();
    decode_complete[0] = 1'b0;
    check32("wrap_pc", pc[0], 32'h0);
    check32("wrap_iaddr", iaddr[0], 32'h0);

    // reset while a request is stalled
    check1("pre_reset_ivalid", ivalid[0], 1'b1);
    #1 reset[0] = 1'b0;
    #1;
    check1("async_ivalid_drop", ivalid[0], 1'b0);
    check32("async_iaddr", iaddr[0], 32'h8000_0000);
    @(negedge clock);
    reset[0] = 1'b1;
    refresh_bus();
    step();
    check1("restart_ivalid", ivalid[0], 1'b1);
    check32("restart_iaddr", iaddr[0], 32'h8000_0000);
    iready[0] = 1'b1;
    step();
    iready[0] = 1'b0;
    check32("restart_pc", pc[0], 32'h8000_0000);
    check32("restart_instr", instr[0], 32'h0050_0093);
    reset[0] = 1'b0;

    // ---------------- RVC instance ----------------
    mem[0] = 32'h4501_4505;
    mem[4] = 32'h0093_0001;
    mem[5] = 32'h4505_0050;
    refresh_bus();
    reset[1] = 1'b1;
    step();
    check1("c_req_ivalid", ivalid[1], 1'b1);
    check32("c_req_iaddr", iaddr[1], 32'h8000_0000);
    a0 = acc[1];
    iready[1] = 1'b1;
    step();
    iready[1] = 1'b0;
    check32("c_lo_instr", instr[1], 32'h0000_4505);
    check1("c_lo_instr_c", instr_c[1], 1'b1);
    check32("c_lo_pc", pc[1], 32'h8000_0000);
    decode_complete[1] = 1'b1;
    step();
    decode_complete[1] = 1'b0;
    check1("c_hit_fv_low", fetch_valid[1], 1'b0);
    check1("c_hit_no_request", ivalid[1], 1'b0);
    step();
    check1("c_hi_fetch_valid", fetch_valid[1], 1'b1);
    check32("c_hi_instr", instr[1], 32'h0000_4501);
    check1("c_hi_instr_c", instr_c[1], 1'b1);
    check32("c_hi_pc", pc[1], 32'h8000_0002);
    check32("c_hit_bus_count", acc[1] - a0, 32'd1);

    // 32-bit instruction spanning two words
    decode_complete[1] = 1'b1; pc_redirect[1] = 1'b1; pc_target[1] = 32'h8000_0013;
    step();
    decode_complete[1] = 1'b0; pc_redirect[1] = 1'b0;
    check32("span_pc", pc[1], 32'h8000_0012);
    check32("span_iaddr0", iaddr[1], 32'h8000_0010);
    check1("span_ivalid0", ivalid[1], 1'b1);
    iready[1] = 1'b1;
    step();
    check1("span_mid_fv", fetch_valid[1], 1'b0);
    check1("span_ivalid1", ivalid[1], 1'b1);
    check32("span_iaddr1", iaddr[1], 32'h8000_0014);
    step();
    iready[1] = 1'b0;
    check1("span_fetch_valid", fetch_valid[1], 1'b1);
    check32("span_instr", instr[1], 32'h0050_0093);
    check1("span_instr_c", instr_c[1], 1'b0);
    check32("span_pc_hold", pc[1], 32'h8000_0012);
    check32("span_bus_count", acc[1] - a0, 32'd3);
    decode_complete[1] = 1'b1;
    step();
    decode_complete[1] = 1'b0;
    check32("after_span_pc", pc[1], 32'h8000_0016);
    check1("after_span_hit", ivalid[1], 1'b0);
    step();
    check32("after_span_instr", instr[1], 32'h0000_4505);
    check1("after_span_instr_c", instr_c[1], 1'b1);
    check32("after_span_bus_count", acc[1] - a0, 32'd3);

    // ---------------- random traffic, both instances ----------------
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b0; iready[d] = 1'b0; decode_complete[d] = 1'b0; pc_redirect[d] = 1'b0;
      m_pc[d] = 32'h8000_0000; m_len[d] = 32'd4; idle[d] = 0;
    end
    step();
    for (int d = 0; d < 2; d++) reset[d] = 1'b1;
    abort = 1'b0;
    for (int cyc = 0; cyc < 3000 && !abort; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        iready[d]          = ($urandom_range(0, 3) != 0);
        decode_complete[d] = ($urandom_range(0, 1) == 0);
        pc_redirect[d]     = ($urandom_range(0, 3) == 0);
        pc_target[d]       = 32'h8000_0000 | 32'($urandom_range(0, 255));
        if (fetch_valid[d] && decode_complete[d])
          m_pc[d] = pc_redirect[d] ? align_target(d, pc_target[d]) : m_pc[d] + m_len[d];
        prev_iv[d]  = ivalid[d];
        prev_rdy[d] = iready[d];
        prev_ia[d]  = iaddr[d];
        prev_fv[d]  = fetch_valid[d];
      end
      step();
      for (int d = 0; d < 2; d++) begin
        if (prev_iv[d] && !prev_rdy[d]) begin
          check1("rnd_ivalid_stable", ivalid[d], 1'b1);
          check32("rnd_iaddr_stable", iaddr[d], prev_ia[d]);
        end
        if (fetch_valid[d] && !prev_fv[d]) begin
          if (d == 0) begin
            e_instr = mem[m_pc[d][7:2]];
            e_c     = 1'b0;
          end else begin
            h = half_at(m_pc[d]);
            if (h[1:0] != 2'b11) begin
              e_instr = {16'h0, h};
              e_c     = 1'b1;
            end else begin
              e_instr = {half_at(m_pc[d] + 32'd2), h};
              e_c     = 1'b0;
            end
          end
          m_len[d] = e_c ? 32'd2 : 32'd4;
          check32("rnd_instr", instr[d], e_instr);
          check1("rnd_instr_c", instr_c[d], e_c);
          check32("rnd_pc", pc[d], m_pc[d]);
          idle[d] = 0;
        end else begin
          idle[d]++;
          if (idle[d] > 64) begin
            check32("rnd_progress_timeout", idle[d], 32'd0);
            abort = 1'b1;
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
